mag_comp_pipe: RTL and testbench
================================

# mag_comp_pipe

Parametrised, pipelined magnitude comparator: compares two WIDTH-bit operands CHUNK bits per stage, MSB chunk first, and reports greater/equal/less flags. Each transaction selects unsigned or two's-complement signed mode. A valid/ready handshake on both sides lets it sit between streaming datapath blocks, where the 8-bit single-cycle unsigned comparator no longer closes timing at wide widths.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK, ≥ 2.
- CHUNK, 8, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.
- TAG_W, 4, width of user tag carried alongside each transaction.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b, is_signed, in_tag are valid.
- in_ready  output  1  block accepts a transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- in_tag  input  TAG_W  user tag, returned unchanged.
- out_valid  output  1  result flags and out_tag are valid.
- out_ready  input  1  downstream consumes the result this cycle.
- a_gt_b  output  1  A > B.
- a_eq_b  output  1  A == B.
- a_lt_b  output  1  A < B.
- a_gtet_b  output  1  A >= B (= a_gt_b | a_eq_b).
- out_tag  output  TAG_W  tag of the reported transaction.

## Operation
- Signed mode: invert bit WIDTH-1 of both operands on entry; then compare unsigned (offset-binary equivalence).
- Stage s (0..STAGES-1) holds: valid bit, decided flag, gt flag, tag, and the operand chunks not yet examined.
- Stage s examines bits [WIDTH-1-s*CHUNK -: CHUNK]. If the incoming decided flag is 1, decided and gt pass through unchanged. Otherwise: chunk_a > chunk_b → decided=1, gt=1; chunk_a < chunk_b → decided=1, gt=0; equal → decided=0.
- Stage 0 takes decided=0 from input.
- Flags are decoded from the last stage: decided&gt → a_gt_b; decided&!gt → a_lt_b; !decided → a_eq_b. Exactly one of the three is 1 whenever out_valid=1.
- Flags and out_tag are don't-care while out_valid=0; the implementation drives them from the last stage regardless.
- Global advance: adv = !out_valid | out_ready. All stage registers load only when adv=1. in_ready = adv.
- A transfer occurs on an edge where in_valid & in_ready. When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Bubbles are not collapsed. A full pipe with out_ready=0 freezes all stages and holds the outputs stable.

## Timing
- Reset (rst_n=0, asynchronous): every stage valid clears; out_valid=0; a_gt_b=a_eq_b=a_lt_b=a_gtet_b=0; out_tag=0. in_ready=1 immediately, since out_valid=0.
- Reset mid-operation discards all in-flight transactions; none are reported after release.
- First transfer is possible on the first rising edge after rst_n deasserts.
- Latency: a transaction transferred at edge k, with no stalls, shows out_valid=1 in the cycle following edge k+STAGES-1 (STAGES=1 → next cycle).
- Throughput: one transaction per cycle while out_ready=1.
- Stall: each cycle with out_valid=1 and out_ready=0 adds one cycle to the latency of every in-flight transaction. in_ready=0 in those cycles.
- Simultaneous output consume and input accept in the same cycle is allowed and loses nothing.
- Output holding: out_valid and the result stay stable until the cycle in which out_ready=1.
- Ordering: strict in-order; out_tag sequence equals the accepted in_tag sequence.

## Test plan
- Reset/idle: hold rst_n=0 with random inputs → out_valid=0, all flags 0, in_ready=1; assert rst_n mid-stream with 3 in flight → none emitted after release.
- Unsigned, WIDTH=32/CHUNK=8: a=0x80000000, b=0x7FFFFFFF, is_signed=0 → a_gt_b=1, a_gtet_b=1, exactly 4 cycles after transfer. a=b=0x12345678 → a_eq_b=1. a=0x12345677, b=0x12345678 → a_lt_b=1 (decided in last stage).
- Signed, same pair: a=0x80000000, b=0x7FFFFFFF, is_signed=1 → a_lt_b=1, a_gtet_b=0. a=0xFFFFFFFF (-1), b=0x00000000 → a_lt_b=1.
- Back-to-back stream: 100 random transactions with tags 0..15 cycling, out_ready=1 → one result per cycle, matches reference model, tags in order.
- Backpressure: random out_ready at 30% duty with random in_valid → no loss or duplication; outputs held stable while out_valid=1 and out_ready=0; in_ready equals !out_valid|out_ready every cycle.
- Parameter sweep: (WIDTH,CHUNK) = (8,8), (8,1), (64,16), with exhaustive 8-bit a,b in both modes for the 8-bit configs → results agree with reference model; latency = 1, 8, 4 cycles respectively.

Source files
------------

// File: rtl/mag_comp_if.sv
// Valid/ready streaming bundle for mag_comp_pipe: operand/tag request side and flag/tag result side.
interface mag_comp_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_gtet_b;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, a, b, is_signed, in_tag, out_ready,
        input  in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, a_gtet_b, out_tag
    );

    modport slave (
        input  in_valid, a, b, is_signed, in_tag, out_ready,
        output in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, a_gtet_b, out_tag
    );
endinterface

// File: rtl/mag_comp_pipe.sv
// Pipelined WIDTH-bit magnitude comparator resolving CHUNK bits per stage, MSB chunk first,
// with a global-advance valid/ready pipeline and a pass-through user tag.
module mag_comp_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4
) (
    input logic       clk,
    input logic       rst_n,
    mag_comp_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    // Returns {decided, gt}; once a higher chunk has decided, lower chunks cannot change the answer.
    function automatic logic [1:0] chunk_step(
        input logic             dec_in,
        input logic             gt_in,
        input logic [CHUNK-1:0] ca,
        input logic [CHUNK-1:0] cb
    );
        logic [1:0] res;
        if (dec_in) begin
            res = {1'b1, gt_in};
        end else if (ca > cb) begin
            res = 2'b11;
        end else if (ca < cb) begin
            res = 2'b10;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    logic             adv_s;
    logic [WIDTH-1:0] a_in_s;
    logic [WIDTH-1:0] b_in_s;

    logic             stg_v_s   [STAGES];
    logic             stg_dec_s [STAGES];
    logic             stg_gt_s  [STAGES];
    logic [TAG_W-1:0] stg_tag_s [STAGES];
    logic [WIDTH-1:0] stg_a_s   [STAGES];
    logic [WIDTH-1:0] stg_b_s   [STAGES];
    logic             nxt_dec_s [STAGES];
    logic             nxt_gt_s  [STAGES];

    logic             v_r   [STAGES];
    logic             dec_r [STAGES];
    logic             gt_r  [STAGES];
    logic [TAG_W-1:0] tag_r [STAGES];
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] b_r   [STAGES];

    logic gt_flag_r;
    logic eq_flag_r;
    logic lt_flag_r;
    logic gtet_flag_r;

    // Advance control and entry bias: flipping the sign bit maps two's complement onto offset binary.
    always_comb begin
        adv_s = ~v_r[LAST] | bus.out_ready;
        if (bus.is_signed) begin
            a_in_s = bus.a ^ SIGN_BIT;
            b_in_s = bus.b ^ SIGN_BIT;
        end else begin
            a_in_s = bus.a;
            b_in_s = bus.b;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_entry
            assign stg_v_s[s]   = bus.in_valid;
            assign stg_dec_s[s] = 1'b0;
            assign stg_gt_s[s]  = 1'b0;
            assign stg_tag_s[s] = bus.in_tag;
            assign stg_a_s[s]   = a_in_s;
            assign stg_b_s[s]   = b_in_s;
        end else begin : g_chain
            assign stg_v_s[s]   = v_r[s-1];
            assign stg_dec_s[s] = dec_r[s-1];
            assign stg_gt_s[s]  = gt_r[s-1];
            assign stg_tag_s[s] = tag_r[s-1];
            assign stg_a_s[s]   = a_r[s-1];
            assign stg_b_s[s]   = b_r[s-1];
        end
        assign {nxt_dec_s[s], nxt_gt_s[s]} = chunk_step(
            stg_dec_s[s], stg_gt_s[s],
            stg_a_s[s][WIDTH-1-s*CHUNK -: CHUNK],
            stg_b_s[s][WIDTH-1-s*CHUNK -: CHUNK]);
    end

    // Pipeline registers and result flags; every stage loads together or the whole pipe holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                v_r[s]   <= 1'b0;
                dec_r[s] <= 1'b0;
                gt_r[s]  <= 1'b0;
                tag_r[s] <= {TAG_W{1'b0}};
                a_r[s]   <= {WIDTH{1'b0}};
                b_r[s]   <= {WIDTH{1'b0}};
            end
            gt_flag_r   <= 1'b0;
            eq_flag_r   <= 1'b0;
            lt_flag_r   <= 1'b0;
            gtet_flag_r <= 1'b0;
        end else if (adv_s) begin
            for (int s = 0; s < STAGES; s++) begin
                v_r[s]   <= stg_v_s[s];
                dec_r[s] <= nxt_dec_s[s];
                gt_r[s]  <= nxt_gt_s[s];
                tag_r[s] <= stg_tag_s[s];
                a_r[s]   <= stg_a_s[s];
                b_r[s]   <= stg_b_s[s];
            end
            gt_flag_r   <= nxt_dec_s[LAST] & nxt_gt_s[LAST];
            eq_flag_r   <= ~nxt_dec_s[LAST];
            lt_flag_r   <= nxt_dec_s[LAST] & ~nxt_gt_s[LAST];
            gtet_flag_r <= ~nxt_dec_s[LAST] | nxt_gt_s[LAST];
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = v_r[LAST];
    assign bus.out_tag   = tag_r[LAST];
    assign bus.a_gt_b    = gt_flag_r;
    assign bus.a_eq_b    = eq_flag_r;
    assign bus.a_lt_b    = lt_flag_r;
    assign bus.a_gtet_b  = gtet_flag_r;
endmodule

// File: tb/tb_mag_comp_pipe.sv
// Self-checking bench for mag_comp_pipe: directed, streaming, backpressure, reset and parameter sweep.
module tb_mag_comp_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mag_comp_if #(.WIDTH(32), .TAG_W(4)) if32 ();
    mag_comp_if #(.WIDTH(8),  .TAG_W(4)) if88 ();
    mag_comp_if #(.WIDTH(8),  .TAG_W(4)) if81 ();
    mag_comp_if #(.WIDTH(64), .TAG_W(4)) if64 ();

    mag_comp_pipe #(.WIDTH(32), .CHUNK(8),  .TAG_W(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    mag_comp_pipe #(.WIDTH(8),  .CHUNK(8),  .TAG_W(4)) u88 (.clk(clk), .rst_n(rst_n), .bus(if88));
    mag_comp_pipe #(.WIDTH(8),  .CHUNK(1),  .TAG_W(4)) u81 (.clk(clk), .rst_n(rst_n), .bus(if81));
    mag_comp_pipe #(.WIDTH(64), .CHUNK(16), .TAG_W(4)) u64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    typedef struct packed {
        logic [1:0] code;
        logic [3:0] tag;
    } exp_t;

    exp_t q32[$];
    exp_t q88[$];
    exp_t q81[$];
    exp_t q64[$];
    int   errors = 0;
    int   checks = 0;

    logic [3:0] fl32, fl88, fl81, fl64;
    assign fl32 = {if32.a_gt_b, if32.a_eq_b, if32.a_lt_b, if32.a_gtet_b};
    assign fl88 = {if88.a_gt_b, if88.a_eq_b, if88.a_lt_b, if88.a_gtet_b};
    assign fl81 = {if81.a_gt_b, if81.a_eq_b, if81.a_lt_b, if81.a_gtet_b};
    assign fl64 = {if64.a_gt_b, if64.a_eq_b, if64.a_lt_b, if64.a_gtet_b};

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Reference: 0 = equal, 1 = greater, 2 = less, using native signed/unsigned arithmetic.
    function automatic logic [1:0] ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                           input bit sgn, input int w);
        logic [63:0] ua, ub;
        longint      sa, sb;
        ua = a << (64 - w);
        ub = b << (64 - w);
        sa = $signed(ua);
        sb = $signed(ub);
        if (sgn) return (sa > sb) ? 2'd1 : ((sa < sb) ? 2'd2 : 2'd0);
        return (ua > ub) ? 2'd1 : ((ua < ub) ? 2'd2 : 2'd0);
    endfunction

    // {gt, eq, lt, gtet}
    function automatic logic [3:0] flags_of(input logic [1:0] code);
        case (code)
            2'd1:    return 4'b1001;
            2'd2:    return 4'b0010;
            default: return 4'b0101;
        endcase
    endfunction

    function automatic logic [63:0] near(input logic [63:0] a, input int chunk, input int nch);
        logic [63:0] m;
        m = {$urandom, $urandom} & ((64'd1 << chunk) - 64'd1);
        m = m << (chunk * $urandom_range(0, nch - 1));
        if ($urandom_range(0, 3) == 0) m = 64'd0;
        if ($urandom_range(0, 3) == 0) m = {$urandom, $urandom};
        return a ^ m;
    endfunction

    task automatic mon(input string nm, input bit got, input exp_t e,
                       input logic [3:0] fl, input logic [3:0] tg);
        chk({nm, "_present"}, 64'(got), 64'd1);
        if (got) begin
            chk({nm, "_flags"}, 64'(fl), 64'(flags_of(e.code)));
            chk({nm, "_tag"}, 64'(tg), 64'(e.tag));
        end
    endtask

    bit         hold_pend = 1'b0;
    logic [8:0] hold_val;
    exp_t       me;
    bit         got;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (if32.out_valid && if32.out_ready) begin
                    got = (q32.size() != 0); me = got ? q32.pop_front() : '0;
                    mon("u32", got, me, fl32, if32.out_tag);
                end
                if (if88.out_valid && if88.out_ready) begin
                    got = (q88.size() != 0); me = got ? q88.pop_front() : '0;
                    mon("u88", got, me, fl88, if88.out_tag);
                end
                if (if81.out_valid && if81.out_ready) begin
                    got = (q81.size() != 0); me = got ? q81.pop_front() : '0;
                    mon("u81", got, me, fl81, if81.out_tag);
                end
                if (if64.out_valid && if64.out_ready) begin
                    got = (q64.size() != 0); me = got ? q64.pop_front() : '0;
                    mon("u64", got, me, fl64, if64.out_tag);
                end
                chk("u32_in_ready", 64'(if32.in_ready), 64'(!if32.out_valid || if32.out_ready));
                if (hold_pend) chk("u32_hold", 64'({if32.out_valid, fl32, if32.out_tag}), 64'(hold_val));
                hold_pend = if32.out_valid && !if32.out_ready;
                hold_val  = {if32.out_valid, fl32, if32.out_tag};
            end
        end
    end

    task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [3:0] t);
        exp_t e;
        if32.in_valid = v; if32.a = a; if32.b = b; if32.is_signed = s; if32.in_tag = t;
        @(negedge clk);
        if (v && if32.in_ready) begin
            e.code = ref_cmp(64'(a), 64'(b), s, 32);
            e.tag  = t;
            q32.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [3:0] t, input logic [3:0] expfl);
        int n;
        drive32(1'b1, a, b, s, t);
        if32.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if32.out_valid && n < 20);
        chk({nm, "_latency"}, 64'(n), 64'd4);
        chk({nm, "_flags"}, 64'(fl32), 64'(expfl));
        @(posedge clk); #1;
    endtask

    task automatic drive_sweep(input logic v, input logic [7:0] a8, input logic [7:0] b8,
                               input logic s8, input logic [63:0] a64, input logic [63:0] b64,
                               input logic s64, input logic [3:0] t);
        exp_t e;
        if88.in_valid = v; if88.a = a8; if88.b = b8; if88.is_signed = s8; if88.in_tag = t;
        if81.in_valid = v; if81.a = a8; if81.b = b8; if81.is_signed = s8; if81.in_tag = t;
        if64.in_valid = v; if64.a = a64; if64.b = b64; if64.is_signed = s64; if64.in_tag = t;
        @(negedge clk);
        e.tag  = t;
        e.code = ref_cmp(64'(a8), 64'(b8), s8, 8);
        if (v && if88.in_ready) q88.push_back(e);
        if (v && if81.in_ready) q81.push_back(e);
        e.code = ref_cmp(a64, b64, s64, 64);
        if (v && if64.in_ready) q64.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        logic [31:0] ra;
        logic [63:0] r64;
        logic [15:0] iv;
        int lat88, lat81, lat64;

        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.is_signed = 1'b0; if32.in_tag = '0;
        if32.out_ready = 1'b1;
        if88.out_ready = 1'b1; if81.out_ready = 1'b1; if64.out_ready = 1'b1;
        if88.in_valid = 1'b0; if81.in_valid = 1'b0; if64.in_valid = 1'b0;

        // Reset with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if32.in_valid = 1'($urandom_range(0, 1)); if32.a = $urandom; if32.b = $urandom;
            if32.is_signed = 1'($urandom_range(0, 1)); if32.in_tag = 4'($urandom_range(0, 15));
            if32.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
            chk("rst_flags", 64'(fl32), 64'd0);
            chk("rst_in_ready", 64'(if32.in_ready), 64'd1);
            chk("rst_out_tag", 64'(if32.out_tag), 64'd0);
        end
        @(posedge clk); #1;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        rst_n = 1'b1;

        directed("u_gt",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 4'd1, 4'b1001);
        directed("u_eq",   32'h1234_5678, 32'h1234_5678, 1'b0, 4'd2, 4'b0101);
        directed("u_lt",   32'h1234_5677, 32'h1234_5678, 1'b0, 4'd3, 4'b0010);
        directed("s_lt",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd4, 4'b0010);
        directed("s_m1lt", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'd5, 4'b0010);

        // Back-to-back stream: one result per cycle once the pipe is full.
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            drive32(1'b1, ra, 32'(near(64'(ra), 8, 4)), 1'($urandom_range(0, 1)), 4'(i % 16));
            if (i >= 3) chk("stream_throughput", 64'(if32.out_valid), 64'd1);
        end
        if32.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("stream_drained", 64'(q32.size()), 64'd0);
        @(posedge clk); #1;

        // Backpressure: out_ready at ~30 percent duty, random in_valid.
        for (int i = 0; i < 300; i++) begin
            if32.out_ready = ($urandom_range(0, 9) < 3);
            ra = $urandom;
            drive32(1'($urandom_range(0, 1)), ra, 32'(near(64'(ra), 8, 4)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_drained", 64'(q32.size()), 64'd0);
        @(posedge clk); #1;

        // Reset with three transactions in flight: none may appear afterwards.
        for (int i = 0; i < 3; i++) drive32(1'b1, $urandom, $urandom, 1'b0, 4'(i));
        if32.in_valid = 1'b0;
        rst_n = 1'b0;
        q32.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", 64'(if32.out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Sweep latency: one transaction into each configuration.
        drive_sweep(1'b1, 8'h5A, 8'hA5, 1'b1, 64'h1, 64'h2, 1'b0, 4'd7);
        if88.in_valid = 1'b0; if81.in_valid = 1'b0; if64.in_valid = 1'b0;
        lat88 = 0; lat81 = 0; lat64 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (if88.out_valid && lat88 == 0) lat88 = n;
            if (if81.out_valid && lat81 == 0) lat81 = n;
            if (if64.out_valid && lat64 == 0) lat64 = n;
        end
        chk("lat_8x8", 64'(lat88), 64'd1);
        chk("lat_8x1", 64'(lat81), 64'd8);
        chk("lat_64x16", 64'(lat64), 64'd4);
        @(posedge clk); #1;

        // Every 8-bit operand pair once, mode by parity; random near-equal 64-bit pairs alongside.
        for (int i = 0; i < 65536; i++) begin
            iv  = 16'(i);
            r64 = {$urandom, $urandom};
            drive_sweep(1'b1, iv[15:8], iv[7:0], ^iv, r64, near(r64, 16, 4),
                        1'($urandom_range(0, 1)), iv[3:0]);
        end
        if88.in_valid = 1'b0; if81.in_valid = 1'b0; if64.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("sweep_drained_8x8", 64'(q88.size()), 64'd0);
        chk("sweep_drained_8x1", 64'(q81.size()), 64'd0);
        chk("sweep_drained_64x16", 64'(q64.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
